// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: frame request/done and received-byte handshake between uart_ctrl and the uart_tx/uart_rx cores
interface uart_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic                  o_tx_start;
  logic [DATA_WIDTH-1:0] o_tx_byte;
  logic                  i_tx_done;
  logic                  i_rx_valid;
  logic [DATA_WIDTH-1:0] i_rx_byte;
  modport master (output o_tx_start, o_tx_byte, input i_tx_done, i_rx_valid, i_rx_byte);
  modport slave (input o_tx_start, o_tx_byte, output i_tx_done, i_rx_valid, i_rx_byte);
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: debounced button/LED front end that sequences uart_tx frames and tallies uart_rx bytes
module uart_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int SW_WIDTH        = 4,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int STRETCH_CYCLES  = 12500000,
  parameter int GAP_CYCLES      = 125000,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic [3:0]            btn,
  input  logic [SW_WIDTH-1:0]   sw,
  uart_ctrl_if.master           bus,
  output logic                  o_rx_en,
  output logic [DATA_WIDTH-1:0] o_rx_last,
  output logic [CNT_WIDTH-1:0]  o_tx_count,
  output logic [CNT_WIDTH-1:0]  o_rx_count,
  output logic                  o_mode_rpt,
  output logic                  o_led5_r,
  output logic                  o_led5_g,
  output logic                  o_led5_b,
  output logic                  o_led6_r,
  output logic                  o_led6_g,
  output logic                  o_led6_b
);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int ST_W  = $clog2(STRETCH_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  state_t           state;
  logic [3:0]       press;
  logic             tx_on, rx_on, tx_evt, rx_evt, gap_end, launch;
  logic [GAP_W-1:0] gap_cnt;
  logic [ST_W-1:0]  tx_st, rx_st;
  for (genvar b = 0; b < 4; b++) begin : g_db
    logic            s1, s2, lvl, p, flip;
    logic [DB_W-1:0] cnt;
    assign flip = s2 != lvl && cnt == DB_W'(DEBOUNCE_CYCLES - 1);
    assign press[b] = p;
    always_ff @(posedge sysclk or negedge rst_n)
      if (!rst_n) begin
        {s1, s2, lvl, p} <= '0;
        cnt <= '0;
      end else begin
        s1 <= btn[b];
        s2 <= s1;
        cnt <= (s2 == lvl || flip) ? '0 : cnt + 1'b1;
        lvl <= lvl ^ flip;
        p <= flip && s2;
      end
  end
  assign tx_evt  = state == WAIT && bus.i_tx_done;
  assign rx_evt  = bus.i_rx_valid && rx_on;
  assign gap_end = state == GAP && gap_cnt == GAP_W'(GAP_CYCLES);
  // one term covers both IDLE->START and GAP->START
  assign launch  = tx_on && (state == IDLE ? o_mode_rpt || press[1] : gap_end && o_mode_rpt);
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.o_tx_start <= 1'b0;
      bus.o_tx_byte <= '0;
      o_tx_count <= '0;
      gap_cnt <= '0;
      tx_on <= 1'b0;
      rx_on <= 1'b0;
      o_mode_rpt <= 1'b0;
    end else begin
      tx_on <= tx_on ^ press[2];
      rx_on <= rx_on ^ press[3];
      o_mode_rpt <= o_mode_rpt ^ press[0];
      bus.o_tx_start <= launch;
      if (launch) bus.o_tx_byte <= DATA_WIDTH'(sw);
      if (tx_evt) o_tx_count <= o_tx_count + 1'b1;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      state <= launch ? START :
               state == START ? WAIT :
               tx_evt ? (tx_on && o_mode_rpt ? GAP : IDLE) :
               gap_end ? IDLE : state;
    end
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      o_rx_last <= '0;
      o_rx_count <= '0;
      tx_st <= '0;
      rx_st <= '0;
    end else begin
      if (rx_evt) o_rx_last <= bus.i_rx_byte;
      if (rx_evt) o_rx_count <= o_rx_count + 1'b1;
      tx_st <= tx_evt ? ST_W'(STRETCH_CYCLES) : tx_st != '0 ? tx_st - 1'b1 : '0;
      rx_st <= rx_evt ? ST_W'(STRETCH_CYCLES) : rx_st != '0 ? rx_st - 1'b1 : '0;
    end
  assign o_rx_en  = rx_on;
  assign o_led5_r = ~tx_on;
  assign o_led5_g = tx_on;
  assign o_led5_b = tx_st != '0;
  assign o_led6_r = ~rx_on;
  assign o_led6_g = rx_on;
  assign o_led6_b = rx_st != '0;
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl with a 5-cycle uart_tx model and a TX byte scoreboard
module tb_uart_ctrl;
  logic       sysclk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] sw;
  logic       o_rx_en, o_mode_rpt;
  logic [7:0] o_rx_last;
  logic [3:0] o_tx_count, o_rx_count;
  logic       o_led5_r, o_led5_g, o_led5_b, o_led6_r, o_led6_g, o_led6_b;
  int         nt, nf, cyc, tx_lat = 5;
  int         starts[$];
  logic [7:0] bytes[$];
  logic [7:0] exp_q[$];
  uart_ctrl_if #(.DATA_WIDTH(8)) u ();
  uart_ctrl #(
    .DATA_WIDTH(8), .SW_WIDTH(4), .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES(10), .GAP_CYCLES(3), .CNT_WIDTH(4)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .btn(btn), .sw(sw), .bus(u),
    .o_rx_en(o_rx_en), .o_rx_last(o_rx_last), .o_tx_count(o_tx_count),
    .o_rx_count(o_rx_count), .o_mode_rpt(o_mode_rpt),
    .o_led5_r(o_led5_r), .o_led5_g(o_led5_g), .o_led5_b(o_led5_b),
    .o_led6_r(o_led6_r), .o_led6_g(o_led6_g), .o_led6_b(o_led6_b)
  );
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;
  // uart_tx model: done pulse occupies the cycle tx_lat cycles after the start cycle
  always begin
    @(negedge sysclk);
    if (u.o_tx_start) begin
      repeat (tx_lat) @(posedge sysclk);
      #1 u.i_tx_done = 1'b1;
      @(posedge sysclk);
      #1 u.i_tx_done = 1'b0;
    end
  end
  always @(negedge sysclk)
    if (u.o_tx_start) begin
      starts.push_back(cyc);
      bytes.push_back(u.o_tx_byte);
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nt++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask
  task automatic press(input int b);
    btn[b] = 1'b1;
    tick(10);
    btn[b] = 1'b0;
    tick(10);
  endtask
  task automatic chk_reset(input string tag);
    check({tag, " tx_start"}, u.o_tx_start, 0);
    check({tag, " tx_byte"}, u.o_tx_byte, 0);
    check({tag, " rx_en"}, o_rx_en, 0);
    check({tag, " rx_last"}, o_rx_last, 0);
    check({tag, " tx_count"}, o_tx_count, 0);
    check({tag, " rx_count"}, o_rx_count, 0);
    check({tag, " mode"}, o_mode_rpt, 0);
    check({tag, " led5 rgb"}, {o_led5_r, o_led5_g, o_led5_b}, 3'b100);
    check({tag, " led6 rgb"}, {o_led6_r, o_led6_g, o_led6_b}, 3'b100);
  endtask
  task automatic drain(input string tag);
    check({tag, " starts"}, bytes.size(), exp_q.size());
    while (bytes.size() > 0 && exp_q.size() > 0) check({tag, " byte"}, bytes.pop_front(), exp_q.pop_front());
    bytes.delete();
    exp_q.delete();
    starts.delete();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    bytes.delete();
    starts.delete();
  endtask
  typedef struct {
    bit         tog;
    logic [7:0] data;
    logic [7:0] exp_last;
    logic [3:0] exp_cnt;
    bit         meas;
  } rx_vec_t;
  rx_vec_t rx_tab[3];
  initial begin
    int k, n, tog, bad;
    logic prev;
    rx_tab[0] = '{1'b0, 8'h5C, 8'h00, 4'd0, 1'b0};
    rx_tab[1] = '{1'b1, 8'h5C, 8'h5C, 4'd1, 1'b0};
    rx_tab[2] = '{1'b0, 8'hA3, 8'hA3, 4'd2, 1'b1};
    rst_n = 1'b0;
    btn = '0;
    sw = '0;
    u.i_rx_valid = 1'b0;
    u.i_rx_byte = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk_reset("reset");
    for (int i = 0; i < 4; i++) begin
      btn[2] = ~i[0];
      tick(1);
    end
    tick(10);
    check("bounce led5_g", o_led5_g, 0);
    btn[2] = 1'b1;
    tog = 0;
    prev = o_led5_g;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) btn[2] = 1'b0;
      tick(1);
      if (o_led5_g != prev) tog++;
      prev = o_led5_g;
    end
    check("held toggles", tog, 1);
    check("held led5 rgb", {o_led5_r, o_led5_g}, 2'b01);
    sw = 4'b1010;
    exp_q.push_back(8'h0A);
    btn[1] = 1'b1;
    k = 0;
    while (!u.o_tx_start && k < 20) begin
      tick(1);
      k++;
    end
    check("single latency", k, 7);
    k = 0;
    while (!o_led5_b && k < 20) begin
      tick(1);
      k++;
    end
    n = 0;
    while (o_led5_b && n < 40) begin
      n++;
      tick(1);
    end
    check("single led5_b cycles", n, 10);
    btn[1] = 1'b0;
    tick(10);
    drain("single");
    check("single tx_count", o_tx_count, 1);
    tx_lat = 20;
    sw = 4'b0011;
    exp_q.push_back(8'h03);
    btn[1] = 1'b1;
    tick(8);
    btn[1] = 1'b0;
    tick(8);
    btn[1] = 1'b1;
    sw = 4'b1111;
    tick(8);
    btn[1] = 1'b0;
    tick(28);
    check("wait drop tx_count", o_tx_count, 2);
    check("wait sw hold", u.o_tx_byte, 8'h03);
    drain("wait drop");
    tx_lat = 5;
    do_reset();
    press(0);
    check("mode rpt", o_mode_rpt, 1);
    sw = 4'b0110;
    for (int i = 0; i < 18; i++) exp_q.push_back(8'h06);
    btn[2] = 1'b1;
    tick(10);
    btn[2] = 1'b0;
    k = 0;
    while (starts.size() < 17 && k < 400) begin
      tick(1);
      k++;
    end
    check("rpt 17 starts seen", starts.size(), 17);
    tick(4);
    btn[2] = 1'b1;
    tick(2);
    check("rpt wrap tx_count", o_tx_count, 1);
    tick(8);
    btn[2] = 1'b0;
    tick(30);
    check("rpt stop tx_count", o_tx_count, 2);
    check("rpt stop led5_g", o_led5_g, 0);
    bad = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != 10) bad++;
    check("rpt bad spacings", bad, 0);
    if (starts.size() > 1) check("rpt first spacing", starts[1] - starts[0], 10);
    drain("rpt");
    for (int i = 0; i < 3; i++) begin
      if (rx_tab[i].tog) press(3);
      u.i_rx_byte = rx_tab[i].data;
      u.i_rx_valid = 1'b1;
      tick(1);
      u.i_rx_valid = 1'b0;
      check($sformatf("rx[%0d] last", i), o_rx_last, rx_tab[i].exp_last);
      check($sformatf("rx[%0d] count", i), o_rx_count, rx_tab[i].exp_cnt);
      if (rx_tab[i].meas) begin
        n = 0;
        while (o_led6_b && n < 40) begin
          n++;
          tick(1);
        end
        check($sformatf("rx[%0d] led6_b cycles", i), n, 10);
      end else tick(3);
    end
    btn[3] = 1'b1;
    tick(6);
    u.i_rx_byte = 8'h11;
    u.i_rx_valid = 1'b1;
    tick(1);
    u.i_rx_valid = 1'b0;
    check("rx off same cycle last", o_rx_last, 8'h11);
    check("rx off same cycle count", o_rx_count, 3);
    check("rx off rx_en", o_rx_en, 0);
    u.i_rx_byte = 8'h22;
    u.i_rx_valid = 1'b1;
    tick(1);
    u.i_rx_valid = 1'b0;
    check("rx off ignored last", o_rx_last, 8'h11);
    btn[3] = 1'b0;
    tick(10);
    exp_q.push_back(8'h06);
    btn[2] = 1'b1;
    tick(7);
    btn[2] = 1'b0;
    k = 0;
    while (!u.o_tx_start && k < 20) begin
      tick(1);
      k++;
    end
    check("midrst start seen", u.o_tx_start, 1);
    tick(2);
    #3 rst_n = 1'b0;
    #1 chk_reset("async reset");
    tick(1);
    rst_n = 1'b1;
    tick(12);
    check("late done tx_count", o_tx_count, 0);
    check("late done led5_b", o_led5_b, 0);
    drain("midrst");
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Parametrised UART control block sitting between the board I/O (buttons, switches, RGB/plain LEDs) and the `uart_tx`/`uart_rx` cores. It debounces the buttons, toggles the independent receiver and transmitter enables, and sequences transmit frames in single-shot or auto-repeat mode. It latches and counts received bytes and stretches the "done" indications so they are visible. Receive and transmit may run simultaneously.

## Interface
Parameters:
- `DATA_WIDTH`, 8: UART payload width.
- `SW_WIDTH`, 4: number of message switches; must be ≤ `DATA_WIDTH`.
- `DEBOUNCE_CYCLES`, 1250000: stable cycles required to accept a button level (10 ms at 125 MHz).
- `STRETCH_CYCLES`, 12500000: blue-LED hold time after a done event.
- `GAP_CYCLES`, 125000: idle cycles between frames in repeat mode; must be ≥ 1.
- `CNT_WIDTH`, 8: width of the frame counters.

Ports:
- `sysclk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `btn`  in  4  raw buttons. [3] toggles RX enable, [2] toggles TX enable, [1] sends a frame (single mode), [0] toggles TX mode.
- `sw`  in  SW_WIDTH  message bits.
- `i_tx_done`  in  1  1-cycle pulse from `uart_tx` at the end of a frame.
- `o_tx_start`  out  1  1-cycle frame request to `uart_tx`.
- `o_tx_byte`  out  DATA_WIDTH  frame payload: `sw` zero-extended, held stable for the whole frame.
- `i_rx_valid`  in  1  1-cycle pulse from `uart_rx` when a byte is complete.
- `i_rx_byte`  in  DATA_WIDTH  received byte; valid with `i_rx_valid`.
- `o_rx_en`  out  1  receiver enable.
- `o_rx_last`  out  DATA_WIDTH  most recently accepted byte.
- `o_tx_count`, `o_rx_count`  out  CNT_WIDTH  completed-frame counters.
- `o_mode_rpt`  out  1  0 = single-shot, 1 = auto-repeat.
- `o_led5_r/g/b`  out  1 each  TX off / TX on / TX done (stretched).
- `o_led6_r/g/b`  out  1 each  RX off / RX on / RX done (stretched).

## Operation
- Debounce, one per button:
  - 2-FF synchroniser, then a counter compared against a stable level.
  - Counter resets whenever the synchronised input equals the stable level.
  - When the counter reaches `DEBOUNCE_CYCLES - 1`, the stable level flips.
  - Press event = 1-cycle pulse on a 0→1 transition of the stable level. Release generates nothing.
- Enables: `rx_on` toggles on btn3 press, `tx_on` on btn2 press, `o_mode_rpt` on btn0 press. `o_rx_en = rx_on`.
- TX FSM states: IDLE, START, WAIT, GAP.
  - IDLE→START when `tx_on` and either (single mode and btn1 press) or repeat mode.
  - START: assert `o_tx_start` for exactly one cycle and latch `o_tx_byte` from `sw`. Next state is WAIT.
  - WAIT: hold until `i_tx_done`, then increment `o_tx_count` and retrigger the TX stretcher. If `tx_on` and repeat mode, go to GAP; otherwise go to IDLE.
  - GAP: count `GAP_CYCLES`. Then go to START if `tx_on` and repeat mode still hold, else IDLE.
  - btn1 presses outside IDLE are dropped, not queued.
- RX path: `i_rx_valid` with `rx_on = 1` latches `o_rx_last`, increments `o_rx_count` and retriggers the RX stretcher. With `rx_on = 0` the pulse is ignored.
- Stretchers: blue LED = 1 while a down-counter is non-zero. A done event reloads it to `STRETCH_CYCLES`, including retriggers while it is already running.
- Counters wrap modulo 2^CNT_WIDTH.
- `o_led5_g = tx_on`, `o_led5_r = ~tx_on`; same pattern for led6 with `rx_on`.

## Timing
- Reset (async assert, sync release on the next `sysclk`):
  - Enables, mode, counters, `o_rx_last`, `o_tx_byte`, `o_tx_start` and blue LEDs are 0. Red LEDs are 1, green LEDs 0.
  - FSM is in IDLE; debounce stable levels are 0.
- Reset mid-frame: FSM returns to IDLE immediately. The next frame needs a new trigger.
- Press latency: a raw level change that stays stable produces the event pulse 2 + `DEBOUNCE_CYCLES` cycles later (±1). The enable/mode register updates one cycle after the pulse.
- Single mode: `o_tx_start` goes high 1 cycle after the btn1 press event (IDLE→START is registered).
- Repeat mode: the start-to-start interval is frame time + 1 (WAIT→GAP) + `GAP_CYCLES` + 1 (GAP→START).
- `tx_on` cleared during WAIT: the current frame completes and is counted, then the FSM goes to IDLE. It never aborts `uart_tx`.
- `i_tx_done` in any state other than WAIT is ignored.
- `sw` changes during a frame do not affect `o_tx_byte` until the next START.
- Simultaneous events: a btn2 press and `i_tx_done` in the same cycle count the frame; the new `tx_on` value governs the GAP/IDLE decision from the next cycle.
- `rx_on` toggled off in the same cycle as `i_rx_valid`: the byte is accepted, because the old `rx_on` value is used.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `STRETCH_CYCLES`=10, `GAP_CYCLES`=3, `CNT_WIDTH`=4. Model `uart_tx` with `i_tx_done` 5 cycles after start.
- Reset and bounce:
  - After `rst_n` release, the outputs match the Timing reset values.
  - A btn2 bounce of 1,0,1,0 on single cycles → no toggle.
  - btn2 held 10 cycles → `tx_on` = 1 and led5_g = 1, exactly one toggle.
- Single shot: `tx_on` = 1, `sw` = 4'b1010, btn1 press → one `o_tx_start` pulse with `o_tx_byte` = 8'h0A. `o_tx_count` = 1 after done; led5_b high for 10 cycles.
  - A second btn1 press during WAIT → no extra frame.
- Repeat: btn0 press, then `tx_on` = 1 → starts spaced 5+1+3+1 = 10 cycles apart.
  - After 17 frames, `o_tx_count` = 1 (wrap).
  - Clearing `tx_on` mid-frame → that frame is counted, then the FSM returns to IDLE.
- RX: `i_rx_valid` with byte 8'h5C while `rx_on` = 0 → ignored.
  - After a btn3 press, bytes 8'h5C then 8'hA3 four cycles apart → `o_rx_last` = 8'hA3, `o_rx_count` = 2.
  - led6_b stays high 10 cycles after the second byte.
- Reset mid-operation: assert `rst_n` low during WAIT in repeat mode → all outputs reach reset values asynchronously. A late `i_tx_done` after release is ignored and the count stays 0.
